// File: rtl/axi_burst_splitter.sv
// rtl/axi_burst_splitter.sv - splits one DMA request into legal AXI AR/AW bursts
module axi_burst_splitter #(
  parameter int AXI_IDW   = 4,
  parameter int AXI_LOCKW = 2,
  parameter int AXI_ADDRW = 32,
  parameter int AXI_LENW  = 4,
  parameter int AXI_SIZE  = 5,
  parameter int BOUND_W   = 12,
  parameter int REQ_BEATW = 12
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_split_en,
  input  logic                 x_burst_disable,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AXI_ADDRW-1:0] req_addr,
  input  logic [REQ_BEATW-1:0] req_beats,
  output logic                 o_axvalid,
  output logic [AXI_IDW-1:0]   o_axid,
  output logic [AXI_ADDRW-1:0] o_axaddr,
  output logic [AXI_LENW-1:0]  o_axlen,
  output logic [2:0]           o_axsize,
  output logic [1:0]           o_axburst,
  output logic [AXI_LOCKW-1:0] o_axlock,
  output logic [3:0]           o_axcache,
  output logic [2:0]           o_axprot,
  input  logic                 i_axready,
  output logic                 o_sub_last,
  output logic                 req_done,
  output logic                 busy,
  output logic [7:0]           sub_cnt
);

  // beat-count arithmetic carries one extra bit so 2^AXI_LENW and a full
  // boundary span are representable alongside the largest request
  localparam int NW = REQ_BEATW + 1;
  localparam logic [NW-1:0] MAX_N = NW'(2 ** AXI_LENW);
  localparam logic [AXI_ADDRW-1:0] LSB_MASK = AXI_ADDRW'((1 << AXI_SIZE) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AXI_ADDRW-1:0] cur_addr_q;
  logic [REQ_BEATW-1:0] rem_q;
  logic [NW-1:0]        n_q;
  logic [AXI_ADDRW-1:0] axaddr_q;
  logic [AXI_LENW-1:0]  axlen_q;
  logic                 sub_last_q;
  logic                 req_done_q;
  logic [7:0]           sub_cnt_q;

  logic [BOUND_W:0]     bnd_bytes;
  logic [NW-1:0]        bnd_beats;
  logic [NW-1:0]        n_calc;
  logic                 ax_hs;

  // beats left before the next boundary; low address bits are always zero
  // here, so this is at least one beat
  assign bnd_bytes = {1'b1, {BOUND_W{1'b0}}} - {1'b0, cur_addr_q[BOUND_W-1:0]};
  assign bnd_beats = NW'(bnd_bytes >> AXI_SIZE);
  assign ax_hs     = (state_q == S_ISSUE) && i_axready;

  // sub-burst size: remaining beats clipped by max length and, optionally, the boundary
  always_comb begin
    n_calc = {1'b0, rem_q};
    if (n_calc > MAX_N) begin
      n_calc = MAX_N;
    end
    if (cfg_split_en && (n_calc > bnd_beats)) begin
      n_calc = bnd_beats;
    end
  end

  // state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; an empty request never leaves IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_beats != '0)) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!x_burst_disable) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_axready) begin
          state_d = sub_last_q ? S_IDLE : S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs; valid is tied to ISSUE so it cannot be withdrawn early
  always_comb begin
    req_ready = (state_q == S_IDLE);
    o_axvalid = (state_q == S_ISSUE);
    busy      = (state_q != S_IDLE);
  end

  // request bookkeeping and registered AX payload
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_addr_q <= '0;
      rem_q      <= '0;
      n_q        <= '0;
      axaddr_q   <= '0;
      axlen_q    <= '0;
      sub_last_q <= 1'b0;
      req_done_q <= 1'b0;
      sub_cnt_q  <= '0;
    end else begin
      req_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cur_addr_q <= req_addr & ~LSB_MASK;
            rem_q      <= req_beats;
            sub_cnt_q  <= '0;
            if (req_beats == '0) begin
              req_done_q <= 1'b1;
            end
          end
        end
        S_CALC: begin
          // recomputed every cycle while held, so cfg_split_en is taken late
          axaddr_q   <= cur_addr_q;
          axlen_q    <= AXI_LENW'(n_calc - NW'(1));
          sub_last_q <= (n_calc == {1'b0, rem_q});
          n_q        <= n_calc;
        end
        S_ISSUE: begin
          if (ax_hs) begin
            cur_addr_q <= cur_addr_q + (AXI_ADDRW'(n_q) << AXI_SIZE);
            rem_q      <= rem_q - REQ_BEATW'(n_q);
            if (sub_cnt_q != 8'hFF) begin
              sub_cnt_q <= sub_cnt_q + 8'd1;
            end
            if (sub_last_q) begin
              req_done_q <= 1'b1;
            end
          end
        end
        default: begin
          rem_q <= rem_q;
        end
      endcase
    end
  end

  assign o_axaddr   = axaddr_q;
  assign o_axlen    = axlen_q;
  assign o_sub_last = sub_last_q;
  assign req_done   = req_done_q;
  assign sub_cnt    = sub_cnt_q;

  assign o_axid     = '0;
  assign o_axsize   = 3'(AXI_SIZE);
  assign o_axburst  = 2'b01;
  assign o_axlock   = '0;
  assign o_axcache  = 4'b0000;
  assign o_axprot   = 3'b000;

endmodule

// File: tb/tb_axi_burst_splitter.sv
// tb/tb_axi_burst_splitter.sv - self-checking bench for axi_burst_splitter
module tb_axi_burst_splitter;

  localparam int BOUND  = 4096;
  localparam int BEAT_B = 32;
  localparam int MAXB   = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_split_en;
  logic        x_burst_disable;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [11:0] req_beats;
  logic        o_axvalid;
  logic [3:0]  o_axid;
  logic [31:0] o_axaddr;
  logic [3:0]  o_axlen;
  logic [2:0]  o_axsize;
  logic [1:0]  o_axburst;
  logic [1:0]  o_axlock;
  logic [3:0]  o_axcache;
  logic [2:0]  o_axprot;
  logic        i_axready;
  logic        o_sub_last;
  logic        req_done;
  logic        busy;
  logic [7:0]  sub_cnt;

  always #5 aclk = ~aclk;

  axi_burst_splitter dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_split_en(cfg_split_en),
    .x_burst_disable(x_burst_disable), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats), .o_axvalid(o_axvalid),
    .o_axid(o_axid), .o_axaddr(o_axaddr), .o_axlen(o_axlen), .o_axsize(o_axsize),
    .o_axburst(o_axburst), .o_axlock(o_axlock), .o_axcache(o_axcache),
    .o_axprot(o_axprot), .i_axready(i_axready), .o_sub_last(o_sub_last),
    .req_done(req_done), .busy(busy), .sub_cnt(sub_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          last;
  } burst_t;

  burst_t exp_q[$];
  burst_t log_q[$];
  int     n_chk    = 0;
  int     n_fail   = 0;
  int     done_cnt = 0;
  bit     pending  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // expected burst list from the splitting rules, in plain integer arithmetic
  task automatic model_push(input logic [31:0] a, input int beats, input bit split);
    longint addr;
    int rem, bnd, n;
    burst_t b;
    addr = a & ~32'h1F;
    rem  = beats;
    while (rem > 0) begin
      bnd = (BOUND - int'(addr % BOUND)) / BEAT_B;
      n = (rem > MAXB) ? MAXB : rem;
      if (split && n > bnd) n = bnd;
      b.addr = addr[31:0];
      b.len  = n - 1;
      b.last = (n == rem);
      exp_q.push_back(b);
      addr = (addr + n * BEAT_B) % 64'h1_0000_0000;
      rem  = rem - n;
    end
  endtask

  // every meaningful cycle: payload against model, valid held until handshake
  always @(negedge aclk) begin
    if (!aresetn) begin
      pending = 1'b0;
    end else begin
      if (pending) chk("valid_held", o_axvalid, 1);
      if (o_axvalid) begin
        chk("model_has_burst", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("axaddr", o_axaddr, exp_q[0].addr);
          chk("axlen", o_axlen, exp_q[0].len);
          chk("sub_last", o_sub_last, exp_q[0].last);
          chk("const_fields", {o_axid, o_axsize, o_axburst, o_axlock, o_axcache, o_axprot},
              {4'h0, 3'd5, 2'b01, 2'b00, 4'h0, 3'h0});
          if (i_axready) begin
            log_q.push_back(exp_q.pop_front());
            pending = 1'b0;
          end else begin
            pending = 1'b1;
          end
        end
      end else begin
        pending = 1'b0;
      end
      if (req_done) done_cnt++;
    end
  end

  task automatic send_req(input logic [31:0] a, input int beats, input bit split, input bit lat);
    model_push(a, beats, split);
    @(posedge aclk); #1;
    cfg_split_en = split;
    req_addr     = a;
    req_beats    = 12'(beats);
    req_valid    = 1'b1;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    if (lat) begin
      chk("latency_cycle1_novalid", o_axvalid, 0);
      @(posedge aclk); #1;
      chk("latency_cycle2_valid", o_axvalid, 1);
    end
  endtask

  task automatic wait_done(input int start, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk); #1;
      if (done_cnt > start) break;
    end
    repeat (3) @(negedge aclk);
    #1;
    chk(name, done_cnt - start, 1);
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic chk_log(input int idx, input logic [31:0] a, input int len, input bit last);
    chk("log_present", log_q.size() > idx, 1);
    if (log_q.size() > idx) begin
      chk("log_addr", log_q[idx].addr, a);
      chk("log_len", log_q[idx].len, len);
      chk("log_last", log_q[idx].last, last);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_axvalid", o_axvalid, 0);
    chk("rst_axaddr", o_axaddr, 0);
    chk("rst_axlen", o_axlen, 0);
    chk("rst_sub_last", o_sub_last, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_sub_cnt", sub_cnt, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
  endtask

  int start;

  initial begin
    aresetn = 1'b0; cfg_split_en = 1'b1; x_burst_disable = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_beats = '0; i_axready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_outputs();
    aresetn = 1'b1;

    // case 1: boundary split of a 16-beat request starting 2 beats below 4 KB
    log_q.delete(); start = done_cnt;
    send_req(32'h0FC0, 16, 1, 1);
    wait_done(start, "c1_done_once");
    chk("c1_count", log_q.size(), 2);
    chk_log(0, 32'h0FC0, 1, 0);
    chk_log(1, 32'h1000, 13, 1);

    // case 2: max-length split of 40 beats
    log_q.delete(); start = done_cnt;
    send_req(32'h0000, 40, 1, 1);
    wait_done(start, "c2_done_once");
    chk("c2_count", log_q.size(), 3);
    chk_log(0, 32'h000, 15, 0);
    chk_log(1, 32'h200, 15, 0);
    chk_log(2, 32'h400, 7, 1);
    chk("c2_sub_cnt", sub_cnt, 3);

    // case 3: boundary split disabled, low address bits ignored
    log_q.delete(); start = done_cnt;
    send_req(32'h0FDF, 16, 0, 1);
    wait_done(start, "c3_done_once");
    chk("c3_count", log_q.size(), 1);
    chk_log(0, 32'h0FC0, 15, 1);
    chk("c3_sub_cnt", sub_cnt, 1);

    // case 4: disable blocks in CALC, ignored in ISSUE; ready stalls
    log_q.delete(); start = done_cnt;
    x_burst_disable = 1'b1; i_axready = 1'b0;
    send_req(32'h0FC0, 16, 1, 0);
    repeat (4) begin
      @(negedge aclk); #1;
      chk("c4_blocked_novalid", o_axvalid, 0);
      chk("c4_blocked_busy", busy, 1);
    end
    @(posedge aclk); #1;
    x_burst_disable = 1'b0;
    @(posedge aclk); #1;
    chk("c4_valid_after_release", o_axvalid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      x_burst_disable = ~x_burst_disable;
      chk("c4_stall_addr", o_axaddr, 32'h0FC0);
      chk("c4_stall_valid", o_axvalid, 1);
    end
    x_burst_disable = 1'b1; i_axready = 1'b1;
    @(posedge aclk); #1;
    i_axready = 1'b0;
    repeat (3) begin
      @(negedge aclk); #1;
      chk("c4_calc_hold_novalid", o_axvalid, 0);
    end
    x_burst_disable = 1'b0; i_axready = 1'b1;
    wait_done(start, "c4_done_once");
    chk("c4_count", log_q.size(), 2);

    // case 5: empty request
    start = done_cnt;
    @(posedge aclk); #1;
    req_addr = 32'h100; req_beats = 12'd0; req_valid = 1'b1;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    chk("c5_done_pulse", req_done, 1);
    chk("c5_ready", req_ready, 1);
    chk("c5_novalid", o_axvalid, 0);
    chk("c5_sub_cnt", sub_cnt, 0);
    @(posedge aclk); #1;
    chk("c5_done_cleared", req_done, 0);
    chk("c5_ready_after", req_ready, 1);
    chk("c5_done_once", done_cnt - start, 1);

    // case 6: reset during the second sub-burst of case 2
    log_q.delete(); start = done_cnt;
    send_req(32'h0000, 40, 1, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk); #1;
      if (log_q.size() >= 1 && o_axvalid) break;
    end
    chk("c6_reached_second", log_q.size(), 1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #2;
    chk_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    chk("c6_no_done", done_cnt - start, 0);
    aresetn = 1'b1;
    log_q.delete(); start = done_cnt;
    send_req(32'h0FC0, 16, 1, 1);
    wait_done(start, "c6_done_once");
    chk("c6_count", log_q.size(), 2);
    chk_log(0, 32'h0FC0, 1, 0);
    chk_log(1, 32'h1000, 13, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
